multi_decade_down_counter: RTL

//  3-digit BCD countdown counter (999..000); the counting-down counterpart of multi_decade_counter.

---
 rtl/multi_decade_down_counter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/multi_decade_down_counter.sv
// multi_decade_down_counter
//   Three-digit BCD countdown counter (999..000) for the ones/tens/hundreds
//   display path. A load strobe captures a BCD preset; the count then steps
//   down once every PRESCALE enabled cycles. done pulses on the cycle the
//   outputs first show 000, and the counter then holds in EXPIRED.
//
//   Optional feature, macro AUTO_RELOAD_EN:
//     The preset from the last load is kept in a shadow register. On the
//     terminal decrement the count reloads from the shadow, done still pulses,
//     and the counter stays in RUN, so the outputs never show 000.
//
//   Handshake: load is a single-cycle strobe with no back-pressure. It is
//   sampled on every rising edge, takes priority over counting in every state,
//   and its effects (new digits, state, busy, load_err) appear on the outputs
//   right after that edge. done and load_err are one-cycle registered pulses.
//
//   state_dbg exposes the FSM state (0 = IDLE, 1 = RUN, 2 = EXPIRED).

module multi_decade_down_counter #(
   parameter int PRESCALE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_ones,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_hund,
   input  logic       enable,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [3:0] hundreds,
   output logic       busy,
   output logic       done,
   output logic       load_err,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   // Prescaler terminal value; PRESCALE is limited to 1..1023 so 10 bits suffice.
   localparam logic [9:0] PRESC_LAST = 10'(PRESCALE - 1);

   state_t     state;
   logic [9:0] presc;

   // Preset digits after clamping anything above 9 down to 9.
   logic [3:0] ld_ones, ld_tens, ld_hund;
   logic       ld_bad;
   logic       ld_zero;

   // Count after one decrement, and whether this decrement reaches 000.
   logic [3:0] dec_ones, dec_tens, dec_hund;
   logic       borrow_tens, borrow_hund;
   logic       is_last;

`ifdef AUTO_RELOAD_EN
   logic [3:0] sh_ones, sh_tens, sh_hund;
`endif

   assign state_dbg = state;

   // Clamp the preset digits and flag any out-of-range digit.
   always_comb begin
      ld_ones = (load_ones > 4'd9) ? 4'd9 : load_ones;
      ld_tens = (load_tens > 4'd9) ? 4'd9 : load_tens;
      ld_hund = (load_hund > 4'd9) ? 4'd9 : load_hund;
      ld_bad  = (load_ones > 4'd9) || (load_tens > 4'd9) || (load_hund > 4'd9);
      ld_zero = (ld_ones == 4'd0) && (ld_tens == 4'd0) && (ld_hund == 4'd0);
   end

   // BCD decrement with borrow ripple; hundreds never wraps below 0.
   always_comb begin
      borrow_tens = (ones == 4'd0);
      borrow_hund = borrow_tens && (tens == 4'd0);
      dec_ones    = borrow_tens ? 4'd9 : ones - 4'd1;
      dec_tens    = borrow_tens ? ((tens == 4'd0) ? 4'd9 : tens - 4'd1) : tens;
      dec_hund    = (borrow_hund && (hundreds != 4'd0)) ? hundreds - 4'd1 : hundreds;
      is_last     = (hundreds == 4'd0) && (tens == 4'd0) && (ones == 4'd1);
   end

   // Main FSM: load has priority; RUN counts prescaled enabled cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         presc    <= 10'd0;
         ones     <= 4'd0;
         tens     <= 4'd0;
         hundreds <= 4'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         load_err <= 1'b0;
`ifdef AUTO_RELOAD_EN
         sh_ones  <= 4'd0;
         sh_tens  <= 4'd0;
         sh_hund  <= 4'd0;
`endif
      end else begin
         done     <= 1'b0;
         load_err <= 1'b0;
         if (load) begin
            ones     <= ld_ones;
            tens     <= ld_tens;
            hundreds <= ld_hund;
            presc    <= 10'd0;
            load_err <= ld_bad;
`ifdef AUTO_RELOAD_EN
            sh_ones  <= ld_ones;
            sh_tens  <= ld_tens;
            sh_hund  <= ld_hund;
`endif
            if (ld_zero) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else begin
               state <= RUN;
               busy  <= 1'b1;
            end
         end else if (state == RUN && enable) begin
            if (presc == PRESC_LAST) begin
               presc <= 10'd0;
               if (is_last) begin
                  done <= 1'b1;
`ifdef AUTO_RELOAD_EN
                  // Shadow is nonzero whenever RUN was entered, so stay in RUN.
                  ones     <= sh_ones;
                  tens     <= sh_tens;
                  hundreds <= sh_hund;
`else
                  ones     <= 4'd0;
                  tens     <= 4'd0;
                  hundreds <= 4'd0;
                  state    <= EXPIRED;
                  busy     <= 1'b0;
`endif
               end else begin
                  ones     <= dec_ones;
                  tens     <= dec_tens;
                  hundreds <= dec_hund;
               end
            end else begin
               presc <= presc + 10'd1;
            end
         end
      end
   end

endmodule
